// File: rtl/input_controller_pkg.sv
// Shared CPU I/O definitions: opcode constants and the input controller state encoding.
package cpu_io_pkg;

  // Opcodes that the I/O blocks care about.
  localparam logic [5:0] OP_IN  = 6'b011101;
  localparam logic [5:0] OP_OUT = 6'b100000;
  localparam logic [5:0] OP_HLT = 6'b011100;

  // Input controller FSM states; the encoding is fixed so other blocks can decode it.
  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    WAIT_PRESS   = 2'd1,
    CAPTURE      = 2'd2,
    WAIT_RELEASE = 2'd3
  } inputState_t;

endpackage

// File: rtl/input_controller_if.sv
// Bundle of the CPU / board signals around the input controller.
// master: CPU and board side (drives opcode, switches, key).
// slave:  the input controller itself.
interface input_controller_if;
  logic [5:0]  operation;
  logic [15:0] switches;
  logic        enterKey;
  logic [31:0] inData;
  logic        inValid;
  logic        stall;
  logic        waitLED;

  modport master (
    output operation, switches, enterKey,
    input  inData, inValid, stall, waitLED
  );

  modport slave (
    input  operation, switches, enterKey,
    output inData, inValid, stall, waitLED
  );
endinterface

// File: rtl/input_controller_key_debouncer.sv
// Key debouncer: two-flop synchronizer followed by a stability counter.
// The clean level only follows the synchronized key after it has disagreed
// with the clean level for DEBOUNCE_CYCLES consecutive cycles.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic clean
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 sync1;
  logic                 sync2;
  logic [CNT_WIDTH-1:0] stableCount;

  // Bring the asynchronous key into the clock domain before anything looks at it.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Count how long the synced key has disagreed with the clean level; flip once it has held long enough.
  always_ff @(posedge clock) begin
    if (reset) begin
      stableCount <= '0;
      clean       <= 1'b0;
    end else if (sync2 == clean) begin
      stableCount <= '0;
    end else if (stableCount == CNT_LAST) begin
      stableCount <= '0;
      clean       <= ~clean;
    end else begin
      stableCount <= stableCount + CNT_ONE;
    end
  end

endmodule

// File: rtl/input_controller.sv
// Input controller for the CPU IN instruction: stalls the core until Enter is
// pressed, then hands the switch value to the writeback path with a one-cycle
// valid pulse. A press must be released before another IN can capture.
// Optional feature: define SIGN_MAG_INPUT_EN to treat switches[15] as a sign
// bit and [14:0] as magnitude (two's complement result); otherwise the
// switches are zero-extended.
module input_controller
  import cpu_io_pkg::*;
#(
  parameter int         DEBOUNCE_CYCLES = 50000,
  parameter int         CNT_WIDTH       = 16,
  parameter logic [5:0] IN_OPCODE       = OP_IN
) (
  input logic               clock,
  input logic               reset,
  input_controller_if.slave io
);

  inputState_t state;
  inputState_t nextState;
  logic        debounced;
  logic [31:0] capturedReg;
  logic        inValidReg;
  logic        waitLedReg;

  // Convert the raw switch pattern into the 32-bit register-file word.
  function automatic logic [31:0] formatInput(input logic [15:0] sw);
`ifdef SIGN_MAG_INPUT_EN
    logic [31:0] mag;
    mag = {17'b0, sw[14:0]};
    return sw[15] ? -mag : mag;
`else
    return {16'h0000, sw};
`endif
  endfunction

  key_debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_WIDTH      (CNT_WIDTH)
  ) u_debouncer (
    .clock(clock),
    .reset(reset),
    .raw  (io.enterKey),
    .clean(debounced)
  );

  // State register; reset aborts any pending IN without capturing.
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  // Next-state logic: wait for a debounced press, capture for one cycle, then wait for release.
  always_comb begin
    nextState = state;
    case (state)
      IDLE:         if (io.operation == IN_OPCODE) nextState = WAIT_PRESS;
      WAIT_PRESS:   if (debounced)                 nextState = CAPTURE;
      CAPTURE:                                     nextState = WAIT_RELEASE;
      WAIT_RELEASE: if (!debounced)                nextState = IDLE;
      default:                                     nextState = IDLE;
    endcase
  end

  // Registered status outputs, aligned with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      inValidReg <= 1'b0;
      waitLedReg <= 1'b0;
    end else begin
      inValidReg <= (nextState == CAPTURE);
      waitLedReg <= (nextState == WAIT_PRESS);
    end
  end

  // Hold the captured word so writeback sees a stable value until the next IN.
  always_ff @(posedge clock) begin
    if (reset) begin
      capturedReg <= 32'h0;
    end else if (state == CAPTURE) begin
      capturedReg <= formatInput(io.switches);
    end
  end

  // During CAPTURE the word is forwarded straight from the switches so writeback
  // can use it in the same cycle the stall drops.
  assign io.inData  = (state == CAPTURE) ? formatInput(io.switches) : capturedReg;
  assign io.inValid = inValidReg;
  assign io.waitLED = waitLedReg;
  assign io.stall   = (io.operation == IN_OPCODE) && (state != CAPTURE);

endmodule

// File: tb/tb_input_controller.sv
// Scoreboard bench for input_controller with a short debounce window.
module tb_input_controller;
  import cpu_io_pkg::*;

  localparam int DEB = 4;

  logic clock = 1'b0;
  logic reset = 1'b1;

  input_controller_if ioBus ();

  input_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_WIDTH      (16),
    .IN_OPCODE      (OP_IN)
  ) dut (
    .clock(clock),
    .reset(reset),
    .io   (ioBus)
  );

  always #5 clock = ~clock;

  int checkCount = 0;
  int errorCount = 0;
  int pushCount  = 0;
  int validCount = 0;
  logic [31:0] expQ[$];

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  // Drive one cycle worth of inputs shortly after the rising edge.
  task automatic applyStimulus(input logic [5:0] op, input logic [15:0] sw, input logic key);
    @(posedge clock);
    #1;
    ioBus.operation = op;
    ioBus.switches  = sw;
    ioBus.enterKey  = key;
  endtask

  task automatic expectCapture(input logic [31:0] word);
    expQ.push_back(word);
    pushCount++;
  endtask

  // Monitor: every valid pulse must match the oldest expected capture.
  always @(negedge clock) begin
    if (ioBus.inValid === 1'b1) begin
      validCount++;
      if (expQ.size() == 0) begin
        checkCount++;
        errorCount++;
        $display("[TB] FAIL spurious_inValid: inData=%h with no capture expected", ioBus.inData);
      end else begin
        checkOutput("capture_inData", ioBus.inData, expQ.pop_front());
      end
    end
  end

  initial begin
    ioBus.operation = 6'd0;
    ioBus.switches  = 16'h0;
    ioBus.enterKey  = 1'b0;
    reset           = 1'b1;
    repeat (3) applyStimulus(6'd0, 16'h0, 1'b0);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("init_inData",  ioBus.inData, 32'h0);
    checkOutput("init_inValid", 32'(ioBus.inValid), 32'h0);
    checkOutput("init_waitLED", 32'(ioBus.waitLED), 32'h0);
    checkOutput("init_stall",   32'(ioBus.stall), 32'h0);
    checkOutput("init_state",   32'(dut.state), 32'(IDLE));

    // Main IN: press at cycle 10, capture in cycle 17; switches change afterwards.
    expectCapture(32'h00001234);
    for (int c = 0; c <= 20; c++) begin
      applyStimulus((c <= 17) ? OP_IN : 6'd0, (c <= 17) ? 16'h1234 : 16'hBEEF, c >= 10);
      @(negedge clock);
      checkOutput("main_stall",   32'(ioBus.stall),   32'(c <= 16));
      checkOutput("main_waitLED", 32'(ioBus.waitLED), 32'(c >= 1 && c <= 16));
      checkOutput("main_inValid", 32'(ioBus.inValid), 32'(c == 17));
      if (c >= 17) checkOutput("main_inData_hold", ioBus.inData, 32'h00001234);
    end
    repeat (10) applyStimulus(6'd0, 16'hBEEF, 1'b0);
    @(negedge clock);
    checkOutput("main_release_state", 32'(dut.state), 32'(IDLE));

    // Key already held when the IN arrives: capture right after WAIT_PRESS entry.
    repeat (10) applyStimulus(6'd0, 16'h00FF, 1'b1);
    expectCapture(32'h000000FF);
    for (int c = 0; c <= 3; c++) begin
      applyStimulus((c <= 2) ? OP_IN : 6'd0, 16'h00FF, 1'b1);
      @(negedge clock);
      checkOutput("held_stall",   32'(ioBus.stall),   32'(c <= 1));
      checkOutput("held_inValid", 32'(ioBus.inValid), 32'(c == 2));
    end
    repeat (10) applyStimulus(6'd0, 16'h00FF, 1'b0);
    @(negedge clock);
    checkOutput("held_release_state", 32'(dut.state), 32'(IDLE));

    // Bouncing key: 1-cycle pulses every 3 cycles never get through.
    for (int c = 0; c <= 34; c++) begin
      applyStimulus(OP_IN, 16'h8005, (c % 3 == 1) && (c < 30));
      @(negedge clock);
      if (c >= 1) checkOutput("bounce_waitLED", 32'(ioBus.waitLED), 32'h1);
    end
    checkOutput("bounce_state", 32'(dut.state), 32'(WAIT_PRESS));

    // Real press with sign/magnitude pattern, then a second IN with the key still held.
`ifdef SIGN_MAG_INPUT_EN
    expectCapture(32'hFFFFFFFB);
`else
    expectCapture(32'h00008005);
`endif
    for (int c = 0; c <= 11; c++) begin
      applyStimulus(OP_IN, 16'h8005, 1'b1);
      @(negedge clock);
      checkOutput("b2b_stall",   32'(ioBus.stall),   32'(c != 7));
      checkOutput("b2b_inValid", 32'(ioBus.inValid), 32'(c == 7));
    end
    for (int c = 0; c <= 9; c++) begin
      applyStimulus(OP_IN, 16'h8000, 1'b1);
      @(negedge clock);
      checkOutput("b2b_held_stall",   32'(ioBus.stall),   32'h1);
      checkOutput("b2b_held_inValid", 32'(ioBus.inValid), 32'h0);
    end
    for (int c = 0; c <= 11; c++) begin
      applyStimulus(OP_IN, 16'h8000, 1'b0);
      @(negedge clock);
      checkOutput("b2b_rel_stall",   32'(ioBus.stall),   32'h1);
      checkOutput("b2b_rel_waitLED", 32'(ioBus.waitLED), 32'(c >= 8));
    end
    checkOutput("b2b_rel_state", 32'(dut.state), 32'(WAIT_PRESS));
`ifdef SIGN_MAG_INPUT_EN
    expectCapture(32'h00000000);
`else
    expectCapture(32'h00008000);
`endif
    for (int c = 0; c <= 11; c++) begin
      applyStimulus((c <= 7) ? OP_IN : 6'd0, 16'h8000, 1'b1);
      @(negedge clock);
      checkOutput("second_stall",   32'(ioBus.stall),   32'(c < 7));
      checkOutput("second_inValid", 32'(ioBus.inValid), 32'(c == 7));
    end
    repeat (10) applyStimulus(6'd0, 16'h8000, 1'b0);
    @(negedge clock);
    checkOutput("second_release_state", 32'(dut.state), 32'(IDLE));

    // Non-IN opcodes with the key toggling: nothing happens.
    for (int c = 0; c <= 39; c++) begin
      applyStimulus((c < 20) ? OP_OUT : OP_HLT, 16'h0F0F, ((c / 7) % 2) == 1);
      @(negedge clock);
      checkOutput("nonin_stall",   32'(ioBus.stall),   32'h0);
      checkOutput("nonin_inValid", 32'(ioBus.inValid), 32'h0);
      checkOutput("nonin_state",   32'(dut.state),     32'(IDLE));
    end
    repeat (10) applyStimulus(6'd0, 16'h0F0F, 1'b0);

    // Reset held 3 cycles in the middle of a wait aborts the IN.
    applyStimulus(OP_IN, 16'h5555, 1'b0);
    @(negedge clock);
    checkOutput("abort_stall_first", 32'(ioBus.stall), 32'h1);
    applyStimulus(OP_IN, 16'h5555, 1'b0);
    @(negedge clock);
    checkOutput("abort_waitLED", 32'(ioBus.waitLED), 32'h1);
    checkOutput("abort_state",   32'(dut.state), 32'(WAIT_PRESS));
    applyStimulus(OP_IN, 16'h5555, 1'b1);
    reset = 1'b1;
    repeat (3) applyStimulus(OP_IN, 16'h5555, 1'b1);
    reset = 1'b0;
    ioBus.enterKey = 1'b0;
    ioBus.operation = 6'd0;
    checkOutput("reset_state",   32'(dut.state),     32'(IDLE));
    checkOutput("reset_inData",  ioBus.inData,       32'h0);
    checkOutput("reset_inValid", 32'(ioBus.inValid), 32'h0);
    checkOutput("reset_waitLED", 32'(ioBus.waitLED), 32'h0);
    ioBus.operation = OP_IN;
    #1;
    checkOutput("reset_stall",   32'(ioBus.stall),   32'h1);
    ioBus.operation = 6'd0;
    repeat (12) applyStimulus(6'd0, 16'h5555, 1'b0);
    @(negedge clock);

    checkOutput("queue_empty",   32'(expQ.size()), 32'h0);
    checkOutput("capture_count", 32'(validCount),  32'(pushCount));

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/input_controller.md
Name: input_controller

Overview:
- Services the CPU IN instruction (opcode 6'b011101): stalls the core until the operator presses the Enter key, then captures the 16 switches into a 32-bit word for the register file.
- It is the input-side counterpart of the display path. It sits between the board switches/key and the CPU writeback mux.
- It provides a one-cycle valid pulse and a wait LED.

Parameters:
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before the debounced key level changes (1 ms at 50 MHz).
- CNT_WIDTH, 16, debounce counter width; must hold DEBOUNCE_CYCLES-1.
- IN_OPCODE, 6'b011101, operation code that requests input.

Ports:
- clock  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high reset
- operation  input  6  opcode of the instruction currently in execute
- switches  input  16  raw board switches, asynchronous, quasi-static
- enterKey  input  1  raw Enter key, active-high after board inversion, asynchronous, bouncy
- inData  output  32  captured input word, held until the next capture
- inValid  output  1  one-cycle pulse; inData is valid for writeback
- stall  output  1  combinational; freezes PC/pipeline while high
- waitLED  output  1  registered; high while awaiting key press

Behaviour:
- Reset (synchronous, active-high; clock and reset as named above):
  - State goes to IDLE.
  - Synchronizer flops, debounce counter and debounced level go to 0.
  - inData = 32'h0, inValid = 0, waitLED = 0.
  - Reset mid-wait aborts the IN with no capture.
- Debouncer:
  - enterKey passes through a 2-flop synchronizer.
  - The counter clears whenever the synced level equals the debounced level. Otherwise it increments.
  - When it reaches DEBOUNCE_CYCLES-1, the debounced level toggles and the counter clears.
  - A stable raw change therefore appears on the debounced level 2+DEBOUNCE_CYCLES cycles later. Glitches shorter than DEBOUNCE_CYCLES are ignored.
- FSM states: IDLE, WAIT_PRESS, CAPTURE, WAIT_RELEASE.
  - IDLE: if operation==IN_OPCODE, go to WAIT_PRESS.
  - WAIT_PRESS: if debounced==1, go to CAPTURE.
  - CAPTURE (exactly one cycle):
    - Register inData from switches (see Optional Feature).
    - Pulse inValid=1.
    - Go to WAIT_RELEASE unconditionally.
  - WAIT_RELEASE: if debounced==0, go to IDLE.
- stall = (operation==IN_OPCODE) && (state != CAPTURE).
  - Stall is asserted in the same cycle an IN first appears in IDLE.
  - Stall drops only during CAPTURE, so the CPU advances exactly once per capture.
- inValid is registered and coincides with the CAPTURE state. inData updates on the CAPTURE→WAIT_RELEASE edge and is visible from the following cycle.
  - To avoid a same-cycle race, the writeback path uses the combinational capture value. The block therefore also drives inData combinationally from switches while in CAPTURE.
  - Implementer choice is fixed: inData is muxed so it equals the captured value in the CAPTURE cycle and holds it afterwards.
- waitLED = 1 exactly while in WAIT_PRESS.
- Boundary conditions:
  - Key already held when an IN arrives: the debounced level is 1, so capture happens on the next cycle after WAIT_PRESS entry.
  - Back-to-back IN instructions: the second IN stalls in WAIT_RELEASE until the key is released. It then goes IDLE→WAIT_PRESS, so one press yields one capture.
  - Non-IN opcodes (OUT, HLT, others): stall=0 and there is no state change from IDLE. An in-progress wait is not cancelled if the opcode changes, because the CPU is frozen.
  - Switch changes are sampled only in CAPTURE. Switches are not synchronized because they are quasi-static.

Optional Feature:
- Macro SIGN_MAG_INPUT_EN.
- Defined: switches[15] is a sign bit and [14:0] the magnitude.
  - inData = sign ? -{17'b0, switches[14:0]} : {17'b0, switches[14:0]}, in 32-bit two's complement. This mirrors the display's sign-magnitude output.
  - Switches 16'h8000 yield 32'h0 (negative zero folds to zero).
- Undefined: inData = {16'h0000, switches} (zero extension).

Decomposition:
- Shared package cpu_io_pkg:
  - opcode constants OP_IN=6'b011101, OP_OUT=6'b100000, OP_HLT=6'b011100;
  - 2-bit state encoding IDLE=0, WAIT_PRESS=1, CAPTURE=2, WAIT_RELEASE=3.
- One sub-module, key_debouncer: 2-flop synchronizer, counter and debounced level. Parameters DEBOUNCE_CYCLES and CNT_WIDTH; ports clock, reset, raw, clean.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset held 3 cycles during WAIT_PRESS -> state IDLE, inData=0, inValid=0, waitLED=0, stall equals (operation==IN).
- operation=IN, switches=16'h1234, key pressed at cycle 10 and held -> stall high from the IN's first cycle; CAPTURE in cycle 17; inValid pulse of width 1; inData=32'h00001234; stall low only in cycle 17.
- Key bounce of 1-cycle pulses every 3 cycles while in WAIT_PRESS -> no capture; waitLED stays 1.
- Two consecutive INs with the key held throughout -> exactly one inValid; the second IN stalls until release, then needs a new press.
- SIGN_MAG_INPUT_EN, switches=16'h8005 -> inData=32'hFFFFFFFB. Switches=16'h8000 -> 32'h0. Without the macro, 16'h8005 -> 32'h00008005.
- operation=OUT or HLT with the key toggling -> stall=0, inValid=0, state remains IDLE.
